fp_mul_arbiter: RTL and testbench

- Shares one combinational fp_mul instance (IEEE-754 single, truncating) among NREQ requesters, e.g. the softmax exp/normalise lanes.
- Round-robin arbitration with a valid/ready request handshake per requester.
- A one-entry registered result stage returns the product tagged with the requester id.
- Sits between the softmax lane controllers and the shared multiplier.

---
 rtl/fp_mul_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin share of one truncating fp32 multiplier
// among NREQ requesters, with a one-entry registered result stage.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester request handshake (bit i)
//   req_a, req_b          operands of requester i in bits [32*i+:32]
//   rsp_valid/rsp_id      result register valid and owning requester
//   rsp_result            truncated fp32 product A*B
//   rsp_ready             bit i: requester i accepts the response
//   stats_clr             synchronous clear of grant counters
//   grant_cnt             per-requester grant count in bits [16*i+:16]
//
// Optional: define FP_MUL_ARB_STATS_EN to build saturating grant
// counters; otherwise grant_cnt reads 0 and stats_clr is ignored.

module fp_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_result,
   input  logic [NREQ-1:0]      rsp_ready,
   input  logic                 stats_clr,
   output logic [16*NREQ-1:0]   grant_cnt
);

   // ------------------------------------------------------------
   // State
   // ------------------------------------------------------------
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [31:0]     rsp_result_q, rsp_result_d;
   logic [IDW-1:0]  ptr_q, ptr_d;

   // ------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------
   logic            slot_free;
   logic            any_valid;
   logic            grant;
   logic [IDW-1:0]  win_idx;

   // The result slot frees up either when empty or when its owner
   // drains it this cycle; other rsp_ready bits are don't-care.
   assign slot_free = !rsp_valid_q || rsp_ready[rsp_id_q];

   // Scan from ptr upward with wrap; scanning in descending distance
   // lets the closest set bit to ptr overwrite the others.
   always_comb begin
      int idx;
      idx       = 0;
      win_idx   = '0;
      any_valid = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (req_valid[idx]) begin
            win_idx   = IDW'(idx);
            any_valid = 1'b1;
         end
      end
   end

   // rst_n gating keeps req_ready low while reset is asserted.
   assign grant = rst_n && slot_free && any_valid;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready = NREQ'(1) << win_idx;
      end
   end

   // ------------------------------------------------------------
   // Shared multiplier (combinational, truncating)
   // ------------------------------------------------------------
   logic [31:0]  win_a, win_b;
   logic         mul_sgn;
   logic [47:0]  mul_prod;
   logic [22:0]  mul_frac;
   logic [7:0]   mul_exp;
   logic         mul_zero;
   logic [31:0]  mul_res;
   logic         unused_prod_lsb;

   assign win_a = req_a[32*int'(win_idx) +: 32];
   assign win_b = req_b[32*int'(win_idx) +: 32];

   always_comb begin
      mul_sgn  = win_a[31] ^ win_b[31];
      mul_zero = (win_a[30:0] == 31'd0) ||
                 (win_b[30:0] == 31'd0);
      mul_prod = {24'd0, 1'b1, win_a[22:0]} *
                 {24'd0, 1'b1, win_b[22:0]};
      // Product of two [1,2) mantissas lies in [1,4); bit 47 set
      // means a one-bit normalise shift and an exponent bump.
      if (mul_prod[47]) begin
         mul_frac = mul_prod[46:24];
      end else begin
         mul_frac = mul_prod[45:23];
      end
      // 8-bit arithmetic gives the mod-256 exponent wrap for free.
      mul_exp = win_a[30:23] + win_b[30:23] - 8'd127
              + {7'd0, mul_prod[47]};
      if (mul_zero) begin
         mul_res = {mul_sgn, 31'd0};
      end else begin
         mul_res = {mul_sgn, mul_exp, mul_frac};
      end
   end

   assign unused_prod_lsb = ^mul_prod[22:0];

   // ------------------------------------------------------------
   // Result stage and pointer next state
   // ------------------------------------------------------------
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      ptr_d        = ptr_q;
      if (grant) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = win_idx;
         rsp_result_d = mul_res;
         if (int'(win_idx) == NREQ - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx + IDW'(1);
         end
      end else if (slot_free) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         ptr_q        <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         ptr_q        <= ptr_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;

   // ------------------------------------------------------------
   // Grant statistics
   // ------------------------------------------------------------
`ifdef FP_MUL_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];
   logic [15:0] cnt_d [NREQ];

   // Clear takes priority over a same-cycle increment.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (stats_clr) begin
            cnt_d[i] = 16'd0;
         end else if (grant && (int'(win_idx) == i) &&
                      (cnt_q[i] != 16'hFFFF)) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= 16'd0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_cnt[16*i +: 16] = cnt_q[i];
      end
   end
`else
   logic unused_stats_clr;

   assign unused_stats_clr = stats_clr;
   assign grant_cnt        = '0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: randomized and directed stimulus for fp_mul_arbiter
// with a queue scoreboard and a real-arithmetic reference multiplier.

module tb_fp_mul_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [32*NREQ-1:0]  req_a;
   logic [32*NREQ-1:0]  req_b;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_result;
   logic [NREQ-1:0]     rsp_ready;
   logic                stats_clr;
   logic [16*NREQ-1:0]  grant_cnt;

   always #5 clk = ~clk;

   fp_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready),
      .stats_clr  (stats_clr),
      .grant_cnt  (grant_cnt)
   );

   typedef struct {
      int          id;
      logic [31:0] res;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_ptr;
   bit m_valid;
   int m_id;
   int m_cnt[NREQ];

   function automatic void check(string name, logic [63:0] act,
                                 logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endfunction

   // Multiply as real numbers (exact for 24x24 bits in a double),
   // then truncate the fraction back to 23 bits.
   function automatic logic [31:0] ref_mul(logic [31:0] a,
                                           logic [31:0] b);
      bit  s;
      real pa, pb, p;
      int  e, m;
      s = a[31] ^ b[31];
      if (a[30:0] == 0 || b[30:0] == 0) return {s, 31'd0};
      pa = 1.0 + real'(a[22:0]) / 8388608.0;
      pb = 1.0 + real'(b[22:0]) / 8388608.0;
      p  = pa * pb;
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p >= 2.0) begin
         p = p / 2.0;
         e = e + 1;
      end
      m = $rtoi((p - 1.0) * 8388608.0);
      return {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) == 0) r[30:0] = '0;
      return r;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 0;
      m_id    = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      sbq.delete();
   endtask

   // One clock: check combinational outputs against the model at the
   // negedge, then advance the model at the posedge. Returns winner.
   task automatic step(output int g);
      bit              slot;
      logic [NREQ-1:0] exp_rdy;
      int              idx;
      @(negedge clk);
      slot = !m_valid || rsp_ready[m_id];
      g    = -1;
      if (slot) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, m_valid);
      for (int i = 0; i < NREQ; i++)
         check("grant_cnt", grant_cnt[16*i +: 16], m_cnt[i]);
      @(posedge clk);
`ifdef FP_MUL_ARB_STATS_EN
      if (stats_clr) begin
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (g >= 0 && m_cnt[g] < 65535) begin
         m_cnt[g]++;
      end
`endif
      if (g >= 0) begin
         sbq.push_back('{g, ref_mul(req_a[32*g +: 32],
                                    req_b[32*g +: 32])});
         m_valid = 1;
         m_id    = g;
         m_ptr   = (g + 1) % NREQ;
      end else if (slot) begin
         m_valid = 0;
      end
      #1;
   endtask

   // Monitor: every response handshake pops the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && rsp_valid === 1'b1 &&
             rsp_ready[rsp_id] === 1'b1) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rsp_unexpected: got id %0d, queue empty",
                        rsp_id);
            end else begin
               mon_e = sbq.pop_front();
               check("rsp_id", rsp_id, mon_e.id);
               check("rsp_result", rsp_result, mon_e.res);
            end
         end
      end
   end

   int              g;
   logic [NREQ-1:0] pv;
   logic [31:0]     ra[NREQ];
   logic [31:0]     rb[NREQ];
   int              rr_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      stats_clr = 1'b0;
      model_reset();

      // Reset state, with requests present to test ready gating
      #12;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_grant_cnt", grant_cnt, 0);
      @(negedge clk);
      req_valid = '0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request: 1.5 * 2.0 = 3.0
      req_valid = 4'b0001;
      req_a[31:0] = 32'h3FC00000;
      req_b[31:0] = 32'h40000000;
      step(g);
      req_valid = '0;
      check("single_valid", rsp_valid, 1);
      check("single_id", rsp_id, 0);
      check("single_result", rsp_result, 32'h40400000);
      step(g);

      // Zero operand with sign from requester 2
      req_valid = 4'b0100;
      req_a[64 +: 32] = 32'h00000000;
      req_b[64 +: 32] = 32'hC0000000;
      step(g);
      req_valid = '0;
      check("zero_id", rsp_id, 2);
      check("zero_result", rsp_result, 32'h80000000);
      step(g);

      // Backpressure: owner id 1 stalls for 3 cycles
      req_valid = 4'b0010;
      req_a[32 +: 32] = 32'h40400000;
      req_b[32 +: 32] = 32'hBF800000;
      step(g);
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = rand_op();
         req_b[32*i +: 32] = rand_op();
      end
      req_valid = '1;
      rsp_ready = 4'b0001;
      repeat (3) begin
         step(g);
         check("bp_id", rsp_id, 1);
         check("bp_result", rsp_result, 32'hC0400000);
      end
      rsp_ready = '1;
      step(g);
      check("bp_regrant_id", rsp_id, 2);
      req_valid = '0;
      step(g);

      // Randomized traffic with hold-until-accepted requesters
      pv = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 1) == 1) begin
               pv[i] = 1'b1;
               ra[i] = rand_op();
               rb[i] = rand_op();
            end
            req_a[32*i +: 32] = ra[i];
            req_b[32*i +: 32] = rb[i];
         end
         req_valid = pv;
         if ($urandom_range(0, 3) == 0)
            rsp_ready = NREQ'($urandom);
         else
            rsp_ready = '1;
         stats_clr = ($urandom_range(0, 99) == 0);
         step(g);
         if (g >= 0) pv[g] = 1'b0;
      end
      stats_clr = 1'b0;
      rsp_ready = '1;
      req_valid = '0;
      step(g);

`ifdef FP_MUL_ARB_STATS_EN
      // Saturation and clear-over-increment
      stats_clr = 1'b1;
      step(g);
      stats_clr = 1'b0;
      req_valid = 4'b1000;
      req_a[96 +: 32] = 32'h3F800000;
      req_b[96 +: 32] = 32'h3F800000;
      repeat (70000) step(g);
      check("cnt_sat", grant_cnt[48 +: 16], 16'hFFFF);
      stats_clr = 1'b1;
      step(g);
      stats_clr = 1'b0;
      check("cnt_clr", grant_cnt[48 +: 16], 0);
      req_valid = '0;
      step(g);
`endif

      // Reset mid-operation with a stalled result
      req_valid = 4'b0001;
      req_a[31:0] = 32'h40000000;
      req_b[31:0] = 32'h40000000;
      rsp_ready = '0;
      step(g);
      req_valid = '0;
      step(g);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_result", rsp_result, 0);
      check("mid_rst_id", rsp_id, 0);
      check("mid_rst_ready", req_ready, 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Round robin from ptr=0 with everyone valid
      rsp_ready = '1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = rand_op();
         req_b[32*i +: 32] = rand_op();
      end
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         step(g);
         check("rr_order", rsp_id, rr_order[k]);
      end

      // Drain and confirm nothing is left outstanding
      req_valid = '0;
      step(g);
      step(g);
      check("sb_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
